// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with configurable data bits, parity and stop bits
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 434,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sclk,
    input  logic                          s_rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_BITS-1:0]          in_data,
    output logic                          rs232_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(BAUD_DIV);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [BW-1:0]        baud;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par;
    logic                 push, pop, baud_end;

    always_comb begin
        in_ready = fifo_level != LW'(FIFO_DEPTH);
        push     = in_valid && in_ready;
        baud_end = baud == BW'(BAUD_DIV - 1);
        pop      = fifo_level != '0 &&
                   (state == IDLE || (state == STOP && baud_end && bit_cnt == 4'(STOP_BITS - 1)));
    end

    always_ff @(posedge sclk)
        if (push) mem[wr_ptr] <= in_data;

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            wr_ptr     <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state    <= IDLE;
            baud     <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par      <= 1'b0;
            rs232_tx <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            rs232_tx <= state == START ? 1'b0 : state == DATA ? shift[0] : state == PAR ? par : 1'b1;
            tx_busy  <= state != IDLE || fifo_level != '0;
            baud     <= (state == IDLE || baud_end) ? '0 : baud + BW'(1);
            if (pop) begin
                shift   <= mem[rd_ptr];
                par     <= ^mem[rd_ptr] ^ (PARITY == 2);
                bit_cnt <= '0;
                state   <= START;
            end else if (baud_end) begin
                case (state)
                    START: begin
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                    DATA: begin
                        shift <= shift >> 1;
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= PARITY != 0 ? PAR : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    PAR: begin
                        bit_cnt <= '0;
                        state   <= STOP;
                    end
                    STOP: begin
                        if (bit_cnt == 4'(STOP_BITS - 1)) state <= IDLE;
                        else bit_cnt <= bit_cnt + 4'd1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, parity, FIFO flow control and reset
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vld [4];
    logic [7:0] vin [4];
    logic       rdy [4];
    logic       tx  [4];
    logic       busy[4];
    logic [2:0] lvl [4];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.BAUD_DIV(8), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) d0 (
        .sclk(clk), .s_rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(vin[0]),
        .rs232_tx(tx[0]), .tx_busy(busy[0]), .fifo_level(lvl[0]));
    uart_tx_fifo #(.BAUD_DIV(8), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) d1 (
        .sclk(clk), .s_rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(vin[1]),
        .rs232_tx(tx[1]), .tx_busy(busy[1]), .fifo_level(lvl[1]));
    uart_tx_fifo #(.BAUD_DIV(8), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) d2 (
        .sclk(clk), .s_rst(rst), .in_valid(vld[2]), .in_ready(rdy[2]), .in_data(vin[2]),
        .rs232_tx(tx[2]), .tx_busy(busy[2]), .fifo_level(lvl[2]));
    uart_tx_fifo #(.BAUD_DIV(8), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) d3 (
        .sclk(clk), .s_rst(rst), .in_valid(vld[3]), .in_ready(rdy[3]), .in_data(vin[3][6:0]),
        .rs232_tx(tx[3]), .tx_busy(busy[3]), .fifo_level(lvl[3]));

    task automatic push1(input int k, input logic [7:0] d);
        vld[k] = 1'b1;
        vin[k] = d;
        @(negedge clk);
        vld[k] = 1'b0;
    endtask

    task automatic rx(input int k, output logic [63:0] b, output int w, output int len);
        b = '0;
        w = 0;
        while (tx[k] !== 1'b0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        len = 0;
        while (busy[k] === 1'b1 && len < 700) begin
            if (len % 8 == 4 && len / 8 < 64) b[len/8] = tx[k];
            @(negedge clk);
            len++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vld[k] = 1'b0;
            vin[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (tx[k] !== 1'b1) begin miscompares++; $display("FAIL reset_tx[%0d] got %b want 1", k, tx[k]); end
            vectors++;
            if (busy[k] !== 1'b0) begin miscompares++; $display("FAIL reset_busy[%0d] got %b want 0", k, busy[k]); end
            vectors++;
            if (lvl[k] !== 3'd0) begin miscompares++; $display("FAIL reset_level[%0d] got %0d want 0", k, lvl[k]); end
            vectors++;
            if (rdy[k] !== 1'b1) begin miscompares++; $display("FAIL reset_ready[%0d] got %b want 1", k, rdy[k]); end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        logic [63:0] b;
        logic [9:0]  want;
        int w, len;
        want = 10'b1010101010;
        push1(0, 8'h55);
        vectors++;
        if (lvl[0] !== 3'd1) begin miscompares++; $display("FAIL basic_level got %0d want 1", lvl[0]); end
        rx(0, b, w, len);
        vectors++;
        if (w !== 2) begin miscompares++; $display("FAIL basic_start_latency got %0d want 2", w); end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (b[i] !== want[i]) begin miscompares++; $display("FAIL basic_bit%0d got %b want %b", i, b[i], want[i]); end
        end
        vectors++;
        if (len !== 80) begin miscompares++; $display("FAIL basic_busy_len got %0d want 80", len); end
        vectors++;
        if (tx[0] !== 1'b1) begin miscompares++; $display("FAIL basic_idle_line got %b want 1", tx[0]); end
    endtask

    task automatic test_parity();
        logic [63:0] b;
        int w, len;
        push1(1, 8'h07);
        rx(1, b, w, len);
        vectors++;
        if (b[10:0] !== {1'b1, 1'b1, 8'h07, 1'b0}) begin miscompares++; $display("FAIL even_07 got %h want %h", b[10:0], {1'b1, 1'b1, 8'h07, 1'b0}); end
        vectors++;
        if (len !== 88) begin miscompares++; $display("FAIL even_07_len got %0d want 88", len); end
        push1(2, 8'h07);
        rx(2, b, w, len);
        vectors++;
        if (b[10:0] !== {1'b1, 1'b0, 8'h07, 1'b0}) begin miscompares++; $display("FAIL odd_07 got %h want %h", b[10:0], {1'b1, 1'b0, 8'h07, 1'b0}); end
        push1(2, 8'h00);
        rx(2, b, w, len);
        vectors++;
        if (b[10:0] !== {1'b1, 1'b1, 8'h00, 1'b0}) begin miscompares++; $display("FAIL odd_00 got %h want %h", b[10:0], {1'b1, 1'b1, 8'h00, 1'b0}); end
    endtask

    task automatic test_seven_two_stop();
        logic [63:0] b;
        int w, len;
        push1(3, 8'h7F);
        rx(3, b, w, len);
        vectors++;
        if (b[9:0] !== 10'b1111111110) begin miscompares++; $display("FAIL d7s2_frame got %b want 1111111110", b[9:0]); end
        vectors++;
        if (len !== 80) begin miscompares++; $display("FAIL d7s2_len got %0d want 80", len); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  wd [6];
        logic [63:0] b;
        int w, len, acc, lowat;
        logic [2:0] lowlvl;
        wd = '{8'hA5, 8'h3C, 8'h01, 8'hFE, 8'h80, 8'h7E};
        acc = 0;
        lowat = -1;
        lowlvl = '0;
        fork
            begin
                for (int cyc = 0; acc < 6 && cyc < 400; cyc++) begin
                    logic r;
                    vld[0] = 1'b1;
                    vin[0] = wd[acc];
                    r = rdy[0];
                    if (!r && lowat < 0) begin
                        lowat = acc;
                        lowlvl = lvl[0];
                    end
                    @(negedge clk);
                    if (r) acc++;
                end
                vld[0] = 1'b0;
            end
            rx(0, b, w, len);
        join
        vectors++;
        if (lowat !== 5) begin miscompares++; $display("FAIL b2b_ready_low_after got %0d want 5", lowat); end
        vectors++;
        if (lowlvl !== 3'd4) begin miscompares++; $display("FAIL b2b_full_level got %0d want 4", lowlvl); end
        vectors++;
        if (acc !== 6) begin miscompares++; $display("FAIL b2b_accepted got %0d want 6", acc); end
        vectors++;
        if (len !== 480) begin miscompares++; $display("FAIL b2b_total_len got %0d want 480", len); end
        for (int f = 0; f < 6; f++) begin
            vectors++;
            if (b[10*f +: 10] !== {1'b1, wd[f], 1'b0}) begin miscompares++; $display("FAIL b2b_frame%0d got %b want %b", f, b[10*f +: 10], {1'b1, wd[f], 1'b0}); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int lows;
        push1(0, 8'h00);
        push1(0, 8'h11);
        push1(0, 8'h22);
        vectors++;
        if (lvl[0] !== 3'd2) begin miscompares++; $display("FAIL midrst_queued got %0d want 2", lvl[0]); end
        repeat (20) @(negedge clk);
        vectors++;
        if (tx[0] !== 1'b0) begin miscompares++; $display("FAIL midrst_data_low got %b want 0", tx[0]); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (tx[0] !== 1'b1) begin miscompares++; $display("FAIL midrst_tx got %b want 1", tx[0]); end
        vectors++;
        if (lvl[0] !== 3'd0) begin miscompares++; $display("FAIL midrst_level got %0d want 0", lvl[0]); end
        vectors++;
        if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", busy[0]); end
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx[0] !== 1'b1) lows++;
        end
        vectors++;
        if (lows !== 0) begin miscompares++; $display("FAIL midrst_quiet got %0d low clocks want 0", lows); end
    endtask

    task automatic test_push_pop_same_edge();
        logic [7:0] exp[$];
        logic [9:0] fb;
        logic [7:0] d, e;
        int pushed;
        exp = {};
        fb = '0;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            exp.push_back(d);
            vld[0] = 1'b1;
            vin[0] = d;
            @(negedge clk);
        end
        vld[0] = 1'b0;
        vectors++;
        if (lvl[0] !== 3'd3) begin miscompares++; $display("FAIL ppop_prefill got %0d want 3", lvl[0]); end
        vectors++;
        if (tx[0] !== 1'b0) begin miscompares++; $display("FAIL ppop_first_start got %b want 0", tx[0]); end
        pushed = 0;
        for (int c = 1; c < 1920; c++) begin
            if (c % 8 == 4) fb[(c % 80) / 8] = tx[0];
            if (c % 80 == 76) begin
                e = exp.size() > 0 ? exp.pop_front() : 8'hXX;
                vectors++;
                if (fb !== {1'b1, e, 1'b0}) begin miscompares++; $display("FAIL ppop_frame%0d got %b want %b", c / 80, fb, {1'b1, e, 1'b0}); end
            end
            if (c % 80 == 78 && pushed < 20) begin
                d = 8'($urandom_range(0, 255));
                exp.push_back(d);
                vld[0] = 1'b1;
                vin[0] = d;
                pushed++;
            end
            if (c % 80 == 79 && vld[0]) begin
                vld[0] = 1'b0;
                vectors++;
                if (lvl[0] !== 3'd3) begin miscompares++; $display("FAIL ppop_level%0d got %0d want 3", c / 80, lvl[0]); end
            end
            @(negedge clk);
        end
        vectors++;
        if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL ppop_end_busy got %b want 0", busy[0]); end
        vectors++;
        if (exp.size() !== 0) begin miscompares++; $display("FAIL ppop_leftover got %0d want 0", exp.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_parity();
        test_seven_two_stop();
        test_back_to_back();
        test_reset_mid_frame();
        test_push_pop_same_edge();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
